jtag_tap_param: RTL and testbench

//  Parametrised IEEE 1149.1 / EJTAG test access port: full 16-state TAP FSM, IR_WIDTH instruction

---
 rtl/jtag_tap_param.sv | 129 ++++++++++++
 tb/tb_jtag_tap_param.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/jtag_tap_param.sv
// IEEE 1149.1 TAP with IDCODE, BYPASS and NUM_DR generic DRs sharing one shift register.
// Capture-to-TDO takes half a TCK; there is no backpressure, and TMS/TDI are sampled on every rising TCK.
module jtag_tap_param #(
  parameter int                     IR_WIDTH   = 5,
  parameter int                     DR_WIDTH   = 32,
  parameter int                     NUM_DR     = 6,
  parameter logic [DR_WIDTH-1:0]    IDCODE_VAL = DR_WIDTH'(32'h1000_0003),
  parameter logic [IR_WIDTH-1:0]    IR_IDCODE  = IR_WIDTH'(5'h01),
  parameter logic [IR_WIDTH-1:0]    DR_BASE    = IR_WIDTH'(5'h02)
) (
  input  logic                        TCK,
  input  logic                        TRST,
  input  logic                        TMS,
  input  logic                        TDI,
  output logic                        TDO,
  output logic                        tdo_en,
  output logic [3:0]                  state_out,
  output logic [IR_WIDTH-1:0]         ir_value,
  input  logic [NUM_DR*DR_WIDTH-1:0]  dr_capture_data,
  output logic [NUM_DR*DR_WIDTH-1:0]  dr_update_data,
  output logic [NUM_DR-1:0]           dr_update
);

  localparam int OFFW = IR_WIDTH + 1;

  typedef enum logic [3:0] {
    TLR      = 4'hF, RTI      = 4'hC, SEL_DR   = 4'h7, CAP_DR   = 4'h6,
    SH_DR    = 4'h2, EX1_DR   = 4'h1, PAUSE_DR = 4'h3, EX2_DR   = 4'h0,
    UPD_DR   = 4'h5, SEL_IR   = 4'h4, CAP_IR   = 4'hE, SH_IR    = 4'hA,
    EX1_IR   = 4'h9, PAUSE_IR = 4'hB, EX2_IR   = 4'h8, UPD_IR   = 4'hD
  } tap_state_t;

  tap_state_t            state, state_nxt;
  logic [IR_WIDTH-1:0]   ir_shift;
  logic [DR_WIDTH-1:0]   dr_shift;
  logic [DR_WIDTH-1:0]   cap_val;
  logic [OFFW-1:0]       dr_off;
  logic [NUM_DR-1:0]     dr_sel;
  logic                  sel_idcode, sel_gen, sel_bypass;

  assign state_out = state;

  always_comb begin
    state_nxt = TLR;
    case (state)
      TLR:      state_nxt = TMS ? TLR      : RTI;
      RTI:      state_nxt = TMS ? SEL_DR   : RTI;
      SEL_DR:   state_nxt = TMS ? SEL_IR   : CAP_DR;
      CAP_DR:   state_nxt = TMS ? EX1_DR   : SH_DR;
      SH_DR:    state_nxt = TMS ? EX1_DR   : SH_DR;
      EX1_DR:   state_nxt = TMS ? UPD_DR   : PAUSE_DR;
      PAUSE_DR: state_nxt = TMS ? EX2_DR   : PAUSE_DR;
      EX2_DR:   state_nxt = TMS ? UPD_DR   : SH_DR;
      UPD_DR:   state_nxt = TMS ? SEL_DR   : RTI;
      SEL_IR:   state_nxt = TMS ? TLR      : CAP_IR;
      CAP_IR:   state_nxt = TMS ? EX1_IR   : SH_IR;
      SH_IR:    state_nxt = TMS ? EX1_IR   : SH_IR;
      EX1_IR:   state_nxt = TMS ? UPD_IR   : PAUSE_IR;
      PAUSE_IR: state_nxt = TMS ? EX2_IR   : PAUSE_IR;
      EX2_IR:   state_nxt = TMS ? UPD_IR   : SH_IR;
      UPD_IR:   state_nxt = TMS ? SEL_DR   : RTI;
      default:  state_nxt = TLR;
    endcase
  end

  // IDCODE wins if its opcode also falls inside the generic window; anything unmapped is BYPASS.
  always_comb begin
    dr_off     = {1'b0, ir_value} - {1'b0, DR_BASE};
    sel_idcode = (ir_value == IR_IDCODE);
    sel_gen    = !sel_idcode && (ir_value >= DR_BASE) && (dr_off < OFFW'(NUM_DR));
    sel_bypass = !sel_idcode && !sel_gen;
    dr_sel     = '0;
    cap_val    = '0;
    if (sel_idcode) cap_val = IDCODE_VAL;
    for (int k = 0; k < NUM_DR; k++) begin
      dr_sel[k] = sel_gen && (dr_off == OFFW'(k));
      if (dr_sel[k]) cap_val = dr_capture_data[k*DR_WIDTH +: DR_WIDTH];
    end
  end

  always_ff @(posedge TCK or negedge TRST) begin
    if (!TRST) begin
      state          <= TLR;
      ir_value       <= IR_IDCODE;
      ir_shift       <= '0;
      dr_shift       <= '0;
      dr_update_data <= '0;
      dr_update      <= '0;
    end else begin
      state     <= state_nxt;
      dr_update <= '0;
      case (state)
        CAP_IR: ir_shift <= {{(IR_WIDTH-2){1'b0}}, 2'b01};
        SH_IR:  ir_shift <= {TDI, ir_shift[IR_WIDTH-1:1]};
        UPD_IR: ir_value <= ir_shift;
        CAP_DR: dr_shift <= cap_val;
        SH_DR: begin
          if (sel_bypass) dr_shift[0] <= TDI;
          else            dr_shift    <= {TDI, dr_shift[DR_WIDTH-1:1]};
        end
        UPD_DR: begin
          dr_update <= dr_sel;
          for (int k = 0; k < NUM_DR; k++)
            if (dr_sel[k]) dr_update_data[k*DR_WIDTH +: DR_WIDTH] <= dr_shift;
        end
        default: ;
      endcase
      // Entering or sitting in TLR forces the IDCODE instruction.
      if (state_nxt == TLR) ir_value <= IR_IDCODE;
    end
  end

  always_ff @(negedge TCK or negedge TRST) begin
    if (!TRST) begin
      TDO    <= 1'b0;
      tdo_en <= 1'b0;
    end else if (state == SH_DR) begin
      TDO    <= dr_shift[0];
      tdo_en <= 1'b1;
    end else if (state == SH_IR) begin
      TDO    <= ir_shift[0];
      tdo_en <= 1'b1;
    end else begin
      TDO    <= 1'b0;
      tdo_en <= 1'b0;
    end
  end

endmodule

// File: tb/tb_jtag_tap_param.sv
// Directed TAP bench: stimulus queues expected TDO bits and update events; a monitor consumes them.
module tb_jtag_tap_param;
  localparam int IRW = 5;
  localparam int DRW = 32;
  localparam int NDR = 6;
  localparam logic [IRW-1:0] IR_CAP = 5'b00001;

  logic TCK = 1'b0, TRST = 1'b0, TMS = 1'b0, TDI = 1'b0, tck_run = 1'b1;
  logic TDO, tdo_en;
  logic [3:0] state_out;
  logic [IRW-1:0] ir_value;
  logic [NDR*DRW-1:0] cap_data, upd_data, upd_model;
  logic [NDR-1:0] dr_update;

  int total = 0;
  int bad = 0;
  logic tdo_q[$];
  logic [NDR-1:0] mask_q[$];
  logic [NDR*DRW-1:0] data_q[$];
  logic exp_bit;
  logic [DRW-1:0] capv;

  jtag_tap_param dut (
    .TCK(TCK), .TRST(TRST), .TMS(TMS), .TDI(TDI), .TDO(TDO), .tdo_en(tdo_en),
    .state_out(state_out), .ir_value(ir_value), .dr_capture_data(cap_data),
    .dr_update_data(upd_data), .dr_update(dr_update)
  );

  initial forever begin
    #10;
    if (tck_run) TCK = ~TCK;
  end

  task automatic check(input string name, input logic [191:0] act, input logic [191:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: TDO is registered on falling TCK, so sample mid low phase.
  initial forever begin
    @(negedge TCK);
    #5;
    if (tdo_en === 1'b1) begin
      if (tdo_q.size() == 0) check("tdo_en idle", tdo_en, 0);
      else begin
        exp_bit = tdo_q.pop_front();
        check("tdo bit", TDO, exp_bit);
      end
    end
    if (dr_update !== '0) begin
      if (mask_q.size() == 0) check("dr_update idle", dr_update, 0);
      else begin
        check("dr_update mask", dr_update, mask_q.pop_front());
        check("dr_update_data", upd_data, data_q.pop_front());
      end
    end
  end

  task automatic tick(input logic tms, input logic tdi);
    TMS = tms;
    TDI = tdi;
    @(posedge TCK);
    #2;
  endtask

  task automatic load_ir(input logic [IRW-1:0] v);
    tick(1, 0); tick(1, 0); tick(0, 0); tick(0, 0);
    for (int i = 0; i < IRW; i++) begin
      tdo_q.push_back(IR_CAP[i]);
      tick(i == IRW-1, v[i]);
    end
    tick(1, 0); tick(0, 0);
    check("ir_value after update", ir_value, v);
  endtask

  task automatic shift_dr(input logic [DRW-1:0] din, input int n,
                          input logic [DRW-1:0] exp, input logic [NDR-1:0] mask);
    tick(1, 0); tick(0, 0); tick(0, 0);
    for (int i = 0; i < n; i++) begin
      tdo_q.push_back(exp[i]);
      tick(i == n-1, din[i]);
    end
    tick(1, 0);
    if (mask != '0) begin
      for (int k = 0; k < NDR; k++)
        if (mask[k]) upd_model[k*DRW +: DRW] = din;
      mask_q.push_back(mask);
      data_q.push_back(upd_model);
    end
    tick(0, 0);
  endtask

  initial begin
    cap_data  = {32'h0BAD_F00D, 32'h4444_4444, 32'h3333_3333,
                 32'hDEAD_BEEF, 32'h1111_1111, 32'h8000_0001};
    upd_model = '0;
    #25;
    check("reset state", state_out, 4'hF);
    check("reset ir_value", ir_value, 5'h01);
    check("reset TDO", TDO, 0);
    check("reset tdo_en", tdo_en, 0);
    check("reset update_data", upd_data, 0);
    check("reset dr_update", dr_update, 0);
    TRST = 1'b1;
    tick(0, 0);
    check("state RTI", state_out, 4'hC);

    shift_dr(32'h0, 32, 32'h1000_0003, 6'b0);           // IDCODE
    load_ir(5'h1F);
    shift_dr(32'hA5, 8, 32'h4A, 6'b0);                  // BYPASS delays by one bit
    load_ir(5'h04);
    shift_dr(32'h1234_5678, 32, 32'hDEAD_BEEF, 6'b000100);
    load_ir(5'h07);
    shift_dr(32'hCAFE_1234, 32, 32'h0BAD_F00D, 6'b100000);
    load_ir(5'h02);
    shift_dr(32'h5555_AAAA, 32, 32'h8000_0001, 6'b000001);
    load_ir(5'h08);                                     // one past last generic DR
    shift_dr(32'h3, 2, 32'h2, 6'b0);
    load_ir(5'h10);
    shift_dr(32'h5, 3, 32'h2, 6'b0);

    // TMS escape to TLR from mid Shift-DR
    load_ir(5'h1F);
    tick(1, 0); tick(0, 0); tick(0, 0);
    tdo_q.push_back(1'b0);
    for (int i = 0; i < 3; i++) begin
      tick(0, 1);
      tdo_q.push_back(1'b1);
    end
    for (int i = 0; i < 5; i++) tick(1, 0);
    check("tms escape state", state_out, 4'hF);
    check("tms escape ir_value", ir_value, 5'h01);
    tick(0, 0);
    check("back to RTI", state_out, 4'hC);

    // Asynchronous TRST with TCK stopped mid Shift-DR
    load_ir(5'h04);
    capv = cap_data[2*DRW +: DRW];
    tick(1, 0); tick(0, 0); tick(0, 0);
    for (int i = 0; i < 3; i++) begin
      tdo_q.push_back(capv[i]);
      tick(0, 0);
    end
    tdo_q.push_back(capv[3]);
    @(negedge TCK);
    #7;
    check("pre-reset TDO", TDO, 1);
    check("pre-reset tdo_en", tdo_en, 1);
    check("pre-reset update_data", upd_data, upd_model);
    tck_run = 1'b0;
    #5 TRST = 1'b0;
    #3;
    check("async state", state_out, 4'hF);
    check("async TDO", TDO, 0);
    check("async tdo_en", tdo_en, 0);
    check("async ir_value", ir_value, 5'h01);
    check("async update_data", upd_data, 0);
    check("async dr_update", dr_update, 0);

    check("tdo queue drained", tdo_q.size(), 0);
    check("update queue drained", mask_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
